stream_matrixify: RTL and testbench

- Inverse direction of dematrixify.
- Accepts a cipher block as a stream of 16 bytes, one per handshake, and assembles it into the 4x4 byte state matrix consumed by the round logic.
- Double-buffered: a completed matrix is held at the output while the next block fills.
- Sits between the byte-wide input interface and the AES round datapath.

---
 rtl/stream_matrixify_pkg.sv | 26 ++
 rtl/stream_matrixify_if.sv | 24 ++
 rtl/stream_matrixify_matrix_place.sv | 26 ++
 rtl/stream_matrixify.sv | 99 +++++++++
 tb/tb_stream_matrixify.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_matrixify_pkg.sv
// Shared definitions for the byte-stream <-> 4x4 state matrix converters.
// The byte_to_rc mapping is common to matrixify, dematrixify and the round logic.
package stream_matrixify_pkg;

    localparam int MATRIX_DIM  = 4;
    localparam int BLOCK_BYTES = MATRIX_DIM * MATRIX_DIM;

    typedef enum logic [0:0] {
        FILLING,
        STALLED
    } fill_state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    // Rawstring byte k sits at column k/4, row k%4.
    function automatic rc_t byte_to_rc(input logic [3:0] k);
        rc_t rc;
        rc.row = k[1:0];
        rc.col = k[3:2];
        return rc;
    endfunction

endpackage

// File: rtl/stream_matrixify_if.sv
// Byte-stream input and matrix output handshakes of stream_matrixify.
// master = producer/consumer side, slave = the matrixify block.
interface stream_matrixify_if;
    import stream_matrixify_pkg::*;

    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_matrix;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   byte_count;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_matrix, out_valid, byte_count
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_matrix, out_valid, byte_count
    );

endinterface

// File: rtl/stream_matrixify_matrix_place.sv
// Places one rawstring byte (index k) into its 4x4 matrix lane as a write mask/data pair.
// matrix[r][c] occupies bits [8*(4r+c)+7 : 8*(4r+c)].
module stream_matrixify_matrix_place
    import stream_matrixify_pkg::*;
(
    input  logic [3:0]   k,
    input  logic [7:0]   data_byte,
    output logic [127:0] mask,
    output logic [127:0] data
);

    rc_t        rc;
    logic [3:0] lane;

    assign rc   = byte_to_rc(k);
    assign lane = {rc.row, rc.col};

    always_comb begin
        // NOTE: defaults first so every bit is assigned on every path and no latch is inferred.
        mask = '0;
        data = '0;
        mask[{lane, 3'b000} +: 8] = 8'hff;
        data[{lane, 3'b000} +: 8] = data_byte;
    end

endmodule

// File: rtl/stream_matrixify.sv
// Assembles a 16-byte stream into the 4x4 AES state matrix, double-buffered so a
// finished block is held at the output while the next one fills.
module stream_matrixify
    import stream_matrixify_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    stream_matrixify_if.slave   bus
);

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

    fill_state_e  state_q;
    logic [127:0] fill_q;
    logic [127:0] hold_q;
    logic [3:0]   count_q;
    logic         hold_full_q;
    logic         ready_q;

    logic [3:0]   k;
    logic [127:0] place_mask;
    logic [127:0] place_data;
    logic [127:0] fill_next;
    logic         in_fire;
    logic         out_fire;
    logic         last_byte;

    assign k         = MSB_FIRST ? (LAST_IDX - count_q) : count_q;
    assign fill_next = (fill_q & ~place_mask) | place_data;
    assign in_fire   = bus.in_valid & ready_q;
    assign out_fire  = hold_full_q & bus.out_ready;
    assign last_byte = (count_q == LAST_IDX);

    stream_matrixify_matrix_place u_place (
        .k         (k),
        .data_byte (bus.in_byte),
        .mask      (place_mask),
        .data      (place_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILLING;
            fill_q      <= '0;
            hold_q      <= '0;
            count_q     <= '0;
            hold_full_q <= 1'b0;
            // NOTE: in_ready is a registered flag reset low, so it stays 0 throughout reset
            // and rises on the first edge after release rather than with the state decode.
            ready_q     <= 1'b0;
        end else if (clear) begin
            state_q     <= FILLING;
            fill_q      <= '0;
            hold_q      <= '0;
            count_q     <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                FILLING: begin
                    ready_q <= 1'b1;
                    if (out_fire) hold_full_q <= 1'b0;
                    if (in_fire) begin
                        fill_q <= fill_next;
                        if (!last_byte) begin
                            count_q <= count_q + 4'd1;
                        end else if (!hold_full_q || bus.out_ready) begin
                            // Hold is free or draining this edge: hand the block over directly.
                            hold_q      <= fill_next;
                            hold_full_q <= 1'b1;
                            count_q     <= '0;
                        end else begin
                            state_q <= STALLED;
                            ready_q <= 1'b0;
                        end
                    end
                end
                STALLED: begin
                    if (out_fire) begin
                        hold_q  <= fill_q;
                        count_q <= '0;
                        state_q <= FILLING;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= FILLING;
            endcase
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.out_valid  = hold_full_q;
    assign bus.out_matrix = hold_q;
    assign bus.byte_count = count_q;

endmodule

// File: tb/tb_stream_matrixify.sv
// Directed bench for stream_matrixify: MSB-first instance for fill/hold/stall/clear/reset,
// LSB-first instance fed with gapped valid.
module tb_stream_matrixify;
    import stream_matrixify_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_a = 1'b0;
    logic clear_b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_matrixify_if ia ();
    stream_matrixify_if ib ();

    stream_matrixify #(.MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .clear(clear_a), .bus(ia));
    stream_matrixify #(.MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .clear(clear_b), .bus(ib));

    localparam logic [127:0] RAW_A = 128'h12637477_1b7a6205_19120d64_04791558;
    localparam logic [127:0] MAT_A = 128'h121b1904_637a1279_74620d15_77056458;
    localparam logic [127:0] RAW_B = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] RAW_C = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] RAW_D = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] RAW_E = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [127:0] RAW_F = 128'h10203040_50607080_90a0b0c0_d0e0f011;
    localparam logic [127:0] RAW_G = 128'h55555555_aaaaaaaa_55555555_aaaaaaaa;
    localparam logic [127:0] RAW_H = 128'h0badf00d_11223344_55667788_99aabb5a;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inverse mapping: matrix lane (4r+c) back to rawstring byte k = 4c+r.
    function automatic logic [127:0] dematrix(input logic [127:0] m);
        logic [127:0] raw;
        raw = '0;
        for (int kk = 0; kk < 16; kk++)
            raw[8*kk +: 8] = m[8*(4*(kk % 4) + kk / 4) +: 8];
        return raw;
    endfunction

    // Streams bytes n=lo..hi of raw MSB-first into dut_a; returns 1 ns after the transfer edge.
    task automatic push_a(input logic [127:0] raw, input int lo, input int hi);
        for (int n = lo; n <= hi; n++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!ia.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check("a_ready_timeout", 128'd0, 128'd1);
            ia.in_valid = 1'b1;
            ia.in_byte  = raw[8*(15-n) +: 8];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_byte = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_byte = '0; ib.out_ready = 1'b0;

        // Reset values while rst_n is held low
        #3;
        check("rst_in_ready",   ia.in_ready,   0);
        check("rst_out_valid",  ia.out_valid,  0);
        check("rst_out_matrix", ia.out_matrix, 0);
        check("rst_byte_count", ia.byte_count, 0);
        check("rst_b_in_ready", ib.in_ready,   0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",   ia.in_ready, 1);
        check("post_rst_b_in_ready", ib.in_ready, 1);

        // Block A, MSB first, consumer ready
        ia.out_ready = 1'b1;
        push_a(RAW_A, 0, 15);
        @(negedge clk);
        ia.in_valid = 1'b0;
        check("a_out_valid",  ia.out_valid,  1);
        check("a_matrix",     ia.out_matrix, MAT_A);
        check("a_m33",        ia.out_matrix[127:120], 8'h12);
        check("a_m22",        ia.out_matrix[87:80],   8'h7a);
        check("a_m02",        ia.out_matrix[23:16],   8'h05);
        check("a_m31",        ia.out_matrix[111:104], 8'h19);
        check("a_m11",        ia.out_matrix[47:40],   8'h0d);
        check("a_m00",        ia.out_matrix[7:0],     8'h58);
        check("a_roundtrip",  dematrix(ia.out_matrix), RAW_A);
        check("a_byte_count", ia.byte_count, 0);
        check("a_in_ready",   ia.in_ready,   1);
        @(negedge clk);
        check("a_drained", ia.out_valid, 0);

        // B held, C fills and stalls
        ia.out_ready = 1'b0;
        push_a(RAW_B, 0, 15);
        push_a(RAW_C, 0, 15);
        @(negedge clk);
        ia.in_byte = 8'hee;
        check("stall_in_ready",   ia.in_ready,   0);
        check("stall_byte_count", ia.byte_count, 15);
        check("stall_out_valid",  ia.out_valid,  1);
        check("stall_holds_b",    dematrix(ia.out_matrix), RAW_B);
        @(negedge clk);
        check("stall_ignores_valid", ia.byte_count, 15);
        check("stall_b_stable",      dematrix(ia.out_matrix), RAW_B);
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        @(posedge clk);
        #1 ia.out_ready = 1'b0;
        @(negedge clk);
        check("unstall_out_valid",  ia.out_valid, 1);
        check("unstall_holds_c",    dematrix(ia.out_matrix), RAW_C);
        check("unstall_in_ready",   ia.in_ready, 1);
        check("unstall_byte_count", ia.byte_count, 0);

        // D's 16th byte coincides with draining C
        push_a(RAW_D, 0, 14);
        check("pre_swap_holds_c", dematrix(ia.out_matrix), RAW_C);
        ia.out_ready = 1'b1;
        push_a(RAW_D, 15, 15);
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b0;
        @(negedge clk);
        check("swap_out_valid",  ia.out_valid, 1);
        check("swap_holds_d",    dematrix(ia.out_matrix), RAW_D);
        check("swap_in_ready",   ia.in_ready, 1);
        check("swap_byte_count", ia.byte_count, 0);

        // clear after 7 bytes of E, with an 8th byte in flight
        push_a(RAW_E, 0, 6);
        check("pre_clear_count", ia.byte_count, 7);
        @(negedge clk);
        clear_a     = 1'b1;
        ia.in_valid = 1'b1;
        ia.in_byte  = 8'hff;
        @(posedge clk);
        #1;
        clear_a     = 1'b0;
        ia.in_valid = 1'b0;
        @(negedge clk);
        check("clear_byte_count", ia.byte_count, 0);
        check("clear_out_valid",  ia.out_valid,  0);
        check("clear_out_matrix", ia.out_matrix, 0);
        check("clear_in_ready",   ia.in_ready,   1);
        push_a(RAW_F, 0, 15);
        @(negedge clk);
        ia.in_valid = 1'b0;
        check("post_clear_valid", ia.out_valid, 1);
        check("post_clear_f",     dematrix(ia.out_matrix), RAW_F);

        // Asynchronous reset between edges while F is held and G is part-filled
        push_a(RAW_G, 0, 4);
        ia.in_valid = 1'b0;
        check("pre_rst_count", ia.byte_count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid",  ia.out_valid,  0);
        check("arst_out_matrix", ia.out_matrix, 0);
        check("arst_byte_count", ia.byte_count, 0);
        check("arst_in_ready",   ia.in_ready,   0);
        #3 rst_n = 1'b1;
        #1;
        check("release_in_ready_low", ia.in_ready, 0);
        @(negedge clk);
        check("release_in_ready", ia.in_ready,  1);
        check("release_valid",    ia.out_valid, 0);

        // LSB-first instance with random gaps on in_valid
        ib.out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            int guard;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                ib.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            guard = 0;
            @(negedge clk);
            while (!ib.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check("b_ready_timeout", 128'd0, 128'd1);
            ib.in_valid = 1'b1;
            ib.in_byte  = RAW_H[8*n +: 8];
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        ib.in_valid = 1'b0;
        check("lsb_out_valid", ib.out_valid, 1);
        check("lsb_m00",       ib.out_matrix[7:0], 8'h5a);
        check("lsb_m10",       ib.out_matrix[39:32], 8'hbb);
        check("lsb_roundtrip", dematrix(ib.out_matrix), RAW_H);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
